// File: rtl/motor_encoder_emulator.sv
// rtl/motor_encoder_emulator.sv - brushed motor plus encoder plant model behind a TB6612-style driver
module motor_encoder_emulator #(
    parameter int WINDOW_CYCLES = 16384,
    parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1),
    parameter int PULSE_THRESH  = 1048576,
    parameter int ACC_W         = 32,
    parameter int INERTIA_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm,
    input  logic             in1,
    input  logic             in2,
    input  logic             stnby,
    output logic             fb,
    output logic             fb_dir,
    output logic [CNT_W-1:0] speed,
    output logic [15:0]      pos,
    output logic             window_tick
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);

    typedef enum logic [2:0] {
        M_STANDBY,
        M_FWD,
        M_REV,
        M_BRAKE,
        M_COAST
    } mode_t;

    mode_t                    mode;
    logic [WIN_W-1:0]         win_cnt;
    logic [CNT_W-1:0]         duty_cnt;
    logic [CNT_W-1:0]         duty_now;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_sum;
    logic                     dir_reg;
    logic                     dir_next;
    logic                     driving;
    logic                     braking;
    logic                     tick;
    logic                     hit;
    logic signed [CNT_W:0]    diff;
    logic signed [CNT_W:0]    step;
    logic [CNT_W-1:0]         speed_next;

    always_comb begin
        mode = M_COAST;
        if (!stnby) begin
            mode = M_STANDBY;
        end else begin
            case ({in1, in2})
                2'b10:   mode = M_FWD;
                2'b01:   mode = M_REV;
                2'b11:   mode = M_BRAKE;
                default: mode = M_COAST;
            endcase
        end
    end

    assign driving     = (mode == M_FWD) || (mode == M_REV);
    assign braking     = (mode == M_BRAKE);
    assign tick        = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign window_tick = tick;
    // Duty as seen at the tick includes the tick cycle itself.
    assign duty_now    = duty_cnt + CNT_W'(pwm && driving);
    assign dir_next    = (mode == M_FWD) ? 1'b1 : (mode == M_REV) ? 1'b0 : dir_reg;

    always_comb begin
        diff = $signed({1'b0, duty_now}) - $signed({1'b0, speed});
        step = diff >>> INERTIA_SHIFT;
        // Without the unit nudge a filtered speed would stall short of the target.
        if (step == '0 && diff != '0) begin
            step = diff[CNT_W] ? '1 : (CNT_W + 1)'(1);
        end
        speed_next = speed + step[CNT_W-1:0];
    end

    assign acc_sum = acc + ACC_W'(speed);
    assign hit     = (acc_sum >= ACC_W'(PULSE_THRESH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            duty_cnt <= '0;
            dir_reg  <= 1'b1;
            fb_dir   <= 1'b1;
            speed    <= '0;
            acc      <= '0;
            fb       <= 1'b0;
            pos      <= '0;
        end else begin
            win_cnt  <= tick ? '0 : win_cnt + 1'b1;
            duty_cnt <= tick ? '0 : duty_now;
            dir_reg  <= dir_next;
            if (tick) begin
                fb_dir <= dir_next;
            end
            if (braking) begin
                speed <= '0;
                acc   <= '0;
                fb    <= 1'b0;
            end else begin
                if (tick) begin
                    speed <= speed_next;
                end
                if (hit) begin
                    acc <= acc_sum - ACC_W'(PULSE_THRESH);
                    fb  <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    fb  <= 1'b0;
                end
            end
            if (fb) begin
                pos <= fb_dir ? pos + 16'd1 : pos - 16'd1;
            end
        end
    end

endmodule

// File: doc/motor_encoder_emulator.md
Name: motor_encoder_emulator

Overview:
- Synthesizable single-channel plant model for one motor: brushed motor plus encoder behind a TB6612-style driver.
- Consumes the driver-side signals the motor controller emits (pwm, in1, in2, stnby) and produces encoder feedback pulses on fb.
- Enables closed-loop bench and on-board testing of the controller without real motors.
- Two instances (left/right) drive the controller's fbl/fbr inputs.

Parameters:
- WINDOW_CYCLES, 16384: duty-measurement window length in clk cycles (≥2).
- CNT_W, $clog2(WINDOW_CYCLES+1): width of the duty and speed values.
- PULSE_THRESH, 1048576: accumulator threshold per encoder pulse (≥ WINDOW_CYCLES).
- ACC_W, 32: phase accumulator width; must hold PULSE_THRESH + WINDOW_CYCLES.
- INERTIA_SHIFT, 0: first-order speed filter shift (0 = no inertia).

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-high reset.
- pwm  in  1  driver PWM input.
- in1  in  1  driver direction input 1.
- in2  in  1  driver direction input 2.
- stnby  in  1  driver enable; low = standby.
- fb  out  1  encoder pulse, one cycle wide.
- fb_dir  out  1  1 = forward, 0 = reverse.
- speed  out  CNT_W  filtered speed (pwm-high cycles per window).
- pos  out  16  signed position count, wraps mod 2^16.
- window_tick  out  1  one-cycle strobe at each window end.

Behaviour:
- Reset (async, rst=1): fb=0, fb_dir=1, speed=0, pos=0, window_tick=0. Window counter, duty counter and accumulator are cleared. Reset asserted mid-operation aborts the window; counting restarts from 0 after release.
- Mode decode, per cycle:
  - stnby=0 → STANDBY.
  - in1=1, in2=0 → FWD.
  - in1=0, in2=1 → REV.
  - in1=1, in2=1 → BRAKE.
  - in1=0, in2=0 → COAST.
- Window counter counts 0..WINDOW_CYCLES-1. window_tick=1 in the cycle the counter holds WINDOW_CYCLES-1; the counter then wraps to 0.
- Duty counter increments on each cycle with pwm=1 and mode FWD or REV, including the tick cycle. Its value at the tick cycle is the window duty (0..WINDOW_CYCLES). The counter clears to 0 on the following cycle.
- Direction register updates on any FWD/REV cycle. fb_dir is updated from it at the tick cycle only.
- Speed update, registered at the tick (visible the cycle after window_tick):
  - diff = duty − speed (signed, CNT_W+1 bits).
  - step = diff >>> INERTIA_SHIFT.
  - If step = 0 and diff ≠ 0, step = sign(diff) (±1).
  - speed ← speed + step. With INERTIA_SHIFT=0, speed = duty.
- BRAKE: in any BRAKE cycle, speed and accumulator clear to 0 on the next edge, overriding a coincident tick. The duty counter keeps running. COAST and STANDBY do not clear speed; it follows the filtered duty (0) at window ends.
- Pulse generation, every cycle when not BRAKE:
  - acc ← acc + speed.
  - If acc + speed ≥ PULSE_THRESH: acc ← acc + speed − PULSE_THRESH, fb=1 that cycle (registered, one cycle).
  - At most one pulse per cycle.
- pos: +1 on fb when fb_dir=1, −1 when fb_dir=0, two's complement wrap (0x7FFF+1 → 0x8000, 0x0000−1 → 0xFFFF).
- Inputs are assumed synchronous to clk; no synchronizers are included.

Test Plan (WINDOW_CYCLES=16, PULSE_THRESH=64, INERTIA_SHIFT=0 unless stated):
- FWD, pwm=1 constant: window_tick every 16 cycles; speed=16 after the first tick; fb every 4 cycles thereafter; pos increments 1,2,3…; fb_dir=1.
- REV, 50% duty (pwm toggles each cycle) from reset: speed=8 after the first tick; fb every 8 cycles; fb_dir=0; pos 0→0xFFFF→0xFFFE.
- FWD full speed, then in1=in2=1 for one cycle mid-window: speed=0 and acc=0 on the next cycle; no fb until the next tick; the resumed window reports duty=15.
- stnby=0 for a full window at speed 16: speed=0 after the next tick; no further fb once acc is below threshold; pos holds.
- INERTIA_SHIFT=2, FWD pwm=1: speed after successive ticks = 4, 7, 9, 10, 11, 12, 13, 14, 15, 16 (±1 rule reaches 16). Then pwm=0: speed decays 12, 9, 6, 4, 3, 2, 1, 0.
- Assert rst for 1 cycle mid-window with pos=5: all outputs reset immediately (async); the first window_tick comes 16 cycles after release.
